// File: rtl/tetris_pkg.sv
// Shared tetromino definitions.
//   piece_type_t       : piece type codes, NONE (0) means "no piece"
//   cell_offset_t      : one unpacked cell offset {dy, dx}, both unsigned
//   cells_per_piece_lp : every tetromino has four cells
//   unpack_cell()      : extract cell k from a 24-bit pattern word
package tetris_pkg;

    localparam int cell_bits_lp       = 6;
    localparam int cells_per_piece_lp = 4;
    localparam int pattern_bits_lp    = cell_bits_lp * cells_per_piece_lp;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        I    = 3'd1,
        O    = 3'd2,
        T    = 3'd3,
        S    = 3'd4,
        Z    = 3'd5,
        J    = 3'd6,
        L    = 3'd7
    } piece_type_t;

    typedef struct packed {
        logic [2:0] dy;
        logic [2:0] dx;
    } cell_offset_t;

    // Cell k lives in bits [6k+5:6k]; dx in the low three, dy in the high three.
    function automatic cell_offset_t unpack_cell(input logic [pattern_bits_lp-1:0] word,
                                                 input logic [1:0]                 k);
        return cell_offset_t'(word[cell_bits_lp*k +: cell_bits_lp]);
    endfunction

endpackage

// File: rtl/piece_cell_emitter.sv
// Piece cell emitter.
// Takes a piece request (type, rotation, origin), reads the pattern word from
// the external piece ROM, and hands the four absolute board cells to the
// consumer one per valid/ready handshake, then pulses done_o.
//
// Ports:
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   req_v_i / req_ready_o    request handshake; ready only when idle
//   req_type_i, req_rot_i    piece type (0 = no piece) and rotation
//   req_x_i, req_y_i         origin column / row
//   rom_addr_o, rom_data_i   registered ROM address {type, rot}; data is
//                            combinational from the address
//   cell_v_o / cell_ready_i  cell handshake
//   cell_x_o, cell_y_o       absolute cell coordinates (one bit wider than
//                            the origin so x+dx never wraps)
//   cell_oob_o               cell lies outside the board (still emitted)
//   cell_last_o              fourth cell of the piece
//   done_o                   one-cycle pulse when the piece is finished
module piece_cell_emitter
    import tetris_pkg::*;
#(
    parameter int width_p        = 24,
    parameter int depth_p        = 32,
    parameter int board_width_p  = 10,
    parameter int board_height_p = 20
) (
    input  logic                                clk_i,
    input  logic                                reset_ni,

    input  logic                                req_v_i,
    output logic                                req_ready_o,
    input  logic [2:0]                          req_type_i,
    input  logic [1:0]                          req_rot_i,
    input  logic [$clog2(board_width_p)-1:0]    req_x_i,
    input  logic [$clog2(board_height_p)-1:0]   req_y_i,

    output logic [$clog2(depth_p)-1:0]          rom_addr_o,
    input  logic [width_p-1:0]                  rom_data_i,

    output logic                                cell_v_o,
    input  logic                                cell_ready_i,
    output logic [$clog2(board_width_p)-1+1:0]  cell_x_o,
    output logic [$clog2(board_height_p)-1+1:0] cell_y_o,
    output logic                                cell_oob_o,
    output logic                                cell_last_o,
    output logic                                done_o
);

    localparam int xw_lp  = $clog2(board_width_p);
    localparam int yw_lp  = $clog2(board_height_p);
    localparam int aw_lp  = $clog2(depth_p);
    localparam int cxw_lp = xw_lp + 1;
    localparam int cyw_lp = yw_lp + 1;

    localparam logic [1:0] last_idx_lp = 2'(cells_per_piece_lp - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [aw_lp-1:0]    addr_q, addr_d;
    logic [width_p-1:0]  word_q, word_d;
    logic [xw_lp-1:0]    x_q, x_d;
    logic [yw_lp-1:0]    y_q, y_d;
    logic                done_q, done_d;
    // Holds req_ready_o low through reset and until the first clock edge
    // after release, so the requester never sees ready during reset.
    logic                ready_en_q;

    cell_offset_t        cur_off;
    piece_type_t         cur_type;

    // The type is the upper three address bits; no separate register needed.
    assign cur_type = piece_type_t'(addr_q[aw_lp-1 -: 3]);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            done_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            x_q        <= x_d;
            y_q        <= y_d;
            done_q     <= done_d;
            ready_en_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        word_d  = word_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_v_i && req_ready_o) begin
                    state_d = FETCH;
                    addr_d  = {req_type_i, req_rot_i};
                    x_d     = req_x_i;
                    y_d     = req_y_i;
                end
            end

            FETCH: begin
                word_d = rom_data_i;
                idx_d  = '0;
                if (cur_type == NONE) begin
                    // Empty piece: finish without emitting anything.
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = EMIT;
                end
            end

            EMIT: begin
                if (cell_ready_i) begin
                    if (idx_q == last_idx_lp) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Cell outputs are combinational from registered state only, so they
    // are inherently stable while the consumer stalls.
    assign cur_off = unpack_cell(word_q, idx_q);

    assign cell_v_o    = (state_q == EMIT);
    assign cell_x_o    = cxw_lp'(x_q) + cxw_lp'(cur_off.dx);
    assign cell_y_o    = cyw_lp'(y_q) + cyw_lp'(cur_off.dy);
    assign cell_oob_o  = (cell_x_o >= cxw_lp'(board_width_p)) ||
                         (cell_y_o >= cyw_lp'(board_height_p));
    assign cell_last_o = cell_v_o && (idx_q == last_idx_lp);

    assign req_ready_o = ready_en_q && (state_q == IDLE);
    assign rom_addr_o  = addr_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_piece_cell_emitter.sv
// Self-checking bench for piece_cell_emitter.
// A behavioural pattern ROM feeds the DUT; each accepted request pushes its
// expected cells into a scoreboard queue, and a monitor pops and compares on
// every cell handshake. Cycle-level timing is checked by the driving thread.
module tb_piece_cell_emitter;

    typedef struct {
        logic [4:0] x;
        logic [5:0] y;
        logic       oob;
        logic       last;
    } cell_t;

    logic        clk;
    logic        reset_ni;
    logic        req_v_i;
    logic        req_ready_o;
    logic [2:0]  req_type_i;
    logic [1:0]  req_rot_i;
    logic [3:0]  req_x_i;
    logic [4:0]  req_y_i;
    logic [4:0]  rom_addr_o;
    logic [23:0] rom_data_i;
    logic        cell_v_o;
    logic        cell_ready_i;
    logic [4:0]  cell_x_o;
    logic [5:0]  cell_y_o;
    logic        cell_oob_o;
    logic        cell_last_o;
    logic        done_o;

    int n_chk = 0;
    int n_err = 0;
    cell_t sb[$];

    piece_cell_emitter #(
        .width_p(24), .depth_p(32), .board_width_p(10), .board_height_p(20)
    ) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o),
        .req_type_i(req_type_i), .req_rot_i(req_rot_i),
        .req_x_i(req_x_i), .req_y_i(req_y_i),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .cell_v_o(cell_v_o), .cell_ready_i(cell_ready_i),
        .cell_x_o(cell_x_o), .cell_y_o(cell_y_o),
        .cell_oob_o(cell_oob_o), .cell_last_o(cell_last_o),
        .done_o(done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] rom_word(input logic [4:0] a);
        if (a == 5'd9) return 24'h242040;
        // Every field is {0, a}: dx = a[2:0], dy = a[4:3].
        return {4{1'b0, a}};
    endfunction

    assign rom_data_i = rom_word(rom_addr_o);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: every valid cell is compared against the scoreboard head; the
    // head is only consumed on a completed handshake.
    always @(negedge clk) begin
        if (reset_ni && cell_v_o) begin
            if (sb.size() == 0) begin
                chk("spurious_cell", 32'd1, 32'd0);
            end else begin
                chk("cell_x",    32'(cell_x_o),    32'(sb[0].x));
                chk("cell_y",    32'(cell_y_o),    32'(sb[0].y));
                chk("cell_oob",  32'(cell_oob_o),  32'(sb[0].oob));
                chk("cell_last", 32'(cell_last_o), 32'(sb[0].last));
                if (cell_ready_i) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; returns in cycle 1.
    task automatic accept(input logic [2:0] ty, input logic [1:0] rot,
                          input logic [3:0] x, input logic [4:0] y);
        int waited = 0;
        logic [23:0] w;
        int xx, yy;
        req_v_i    = 1'b1;
        req_type_i = ty;
        req_rot_i  = rot;
        req_x_i    = x;
        req_y_i    = y;
        while (!req_ready_o && waited < 20) begin
            tick();
            waited++;
        end
        if (!req_ready_o) chk("accept_timeout", 32'd1, 32'd0);
        w = rom_word({ty, rot});
        if (ty != 3'd0) begin
            for (int k = 0; k < 4; k++) begin
                cell_t c;
                xx = int'(x) + int'((w >> (6 * k)) & 24'h7);
                yy = int'(y) + int'((w >> (6 * k + 3)) & 24'h7);
                c.x    = 5'(xx);
                c.y    = 6'(yy);
                c.oob  = (xx >= 10) || (yy >= 20);
                c.last = (k == 3);
                sb.push_back(c);
            end
        end
        tick();
        req_v_i = 1'b0;
    endtask

    // Walk cycles 1..exp_done after acceptance; optional stall on cell 1
    // (cycles 3 .. 3+stall-1). Returns in the done cycle.
    task automatic run_piece(input logic [2:0] ty, input logic [1:0] rot,
                             input int stall, input int exp_done);
        for (int c = 1; c <= exp_done; c++) begin
            cell_ready_i = !(c >= 3 && c < 3 + stall);
            if (c == 1) chk("rom_addr", 32'(rom_addr_o), 32'({ty, rot}));
            if (c < 2 || ty == 3'd0) chk("no_cell_yet", 32'(cell_v_o), 32'd0);
            if (c == 2 && ty != 3'd0) chk("cell0_valid", 32'(cell_v_o), 32'd1);
            chk("done_timing", 32'(done_o), 32'(c == exp_done));
            if (c == exp_done) begin
                chk("ready_at_done", 32'(req_ready_o), 32'd1);
                chk("sb_empty", 32'(sb.size()), 32'd0);
            end else begin
                tick();
            end
        end
        cell_ready_i = 1'b1;
    endtask

    initial begin
        reset_ni     = 1'b0;
        req_v_i      = 1'b0;
        req_type_i   = '0;
        req_rot_i    = '0;
        req_x_i      = '0;
        req_y_i      = '0;
        cell_ready_i = 1'b1;

        tick();
        tick();
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_cell_v", 32'(cell_v_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_addr", 32'(rom_addr_o), 32'd0);
        chk("rst_cell_x", 32'(cell_x_o), 32'd0);
        chk("rst_cell_y", 32'(cell_y_o), 32'd0);
        chk("rst_oob", 32'(cell_oob_o), 32'd0);
        chk("rst_last", 32'(cell_last_o), 32'd0);
        reset_ni = 1'b1;
        tick();
        chk("ready_after_rst", 32'(req_ready_o), 32'd1);

        // Basic emit.
        accept(3'd2, 2'd1, 4'd3, 5'd5);
        run_piece(3'd2, 2'd1, 0, 6);
        tick();
        chk("addr_hold_idle", 32'(rom_addr_o), 32'd9);

        // Out of bounds.
        accept(3'd2, 2'd1, 4'd8, 5'd19);
        run_piece(3'd2, 2'd1, 0, 6);
        tick();

        // Backpressure on cell 1.
        accept(3'd2, 2'd1, 4'd3, 5'd5);
        run_piece(3'd2, 2'd1, 3, 9);
        tick();

        // Empty piece.
        accept(3'd0, 2'd2, 4'd4, 5'd4);
        run_piece(3'd0, 2'd2, 0, 2);
        tick();

        // Far corner, large offsets: x/y must not wrap.
        accept(3'd7, 2'd3, 4'd9, 5'd15);
        run_piece(3'd7, 2'd3, 0, 6);
        tick();

        // Back-to-back: second request accepted in the done cycle.
        accept(3'd3, 2'd0, 4'd1, 5'd2);
        run_piece(3'd3, 2'd0, 0, 6);
        accept(3'd2, 2'd1, 4'd0, 5'd0);
        run_piece(3'd2, 2'd1, 0, 6);
        tick();

        // Reset after the cell-1 handshake.
        accept(3'd5, 2'd2, 4'd2, 5'd3);
        tick();          // cycle 2: cell 0
        tick();          // cycle 3: cell 1 accepted at the next edge
        tick();          // cycle 4: cell 2 on the outputs
        reset_ni = 1'b0;
        #1;
        chk("rst_mid_cell_v", 32'(cell_v_o), 32'd0);
        chk("rst_mid_ready", 32'(req_ready_o), 32'd0);
        sb.delete();
        tick();
        reset_ni = 1'b1;
        tick();
        chk("ready_after_mid_rst", 32'(req_ready_o), 32'd1);
        for (int c = 0; c < 6; c++) begin
            chk("no_done_after_rst", 32'(done_o), 32'd0);
            chk("no_cell_after_rst", 32'(cell_v_o), 32'd0);
            tick();
        end

        // Normal operation resumes after the reset.
        accept(3'd2, 2'd1, 4'd3, 5'd5);
        run_piece(3'd2, 2'd1, 0, 6);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
